// File: rtl/zeroriscy_instr_profiler_pkg.sv
// Shared definitions for the retired-instruction profiler and tracer: opcodes,
// PPU funct7 codes, the instruction class enum and the class decode function.
package zeroriscy_instr_profiler_pkg;

    localparam logic [6:0] OPCODE_SYSTEM = 7'h73;
    localparam logic [6:0] OPCODE_OP     = 7'h33;
    localparam logic [6:0] OPCODE_OPIMM  = 7'h13;
    localparam logic [6:0] OPCODE_STORE  = 7'h23;
    localparam logic [6:0] OPCODE_LOAD   = 7'h03;
    localparam logic [6:0] OPCODE_BRANCH = 7'h63;
    localparam logic [6:0] OPCODE_JALR   = 7'h67;
    localparam logic [6:0] OPCODE_JAL    = 7'h6f;
    localparam logic [6:0] OPCODE_AUIPC  = 7'h17;
    localparam logic [6:0] OPCODE_LUI    = 7'h37;
    localparam logic [6:0] OPCODE_PPU    = 7'h53;

    localparam logic [6:0] PPU_F7_ARITH = 7'b1101010;
    localparam logic [6:0] PPU_F7_F2P   = 7'b1101000;
    localparam logic [6:0] PPU_F7_P2F   = 7'b1101001;

    localparam logic [31:0] INSTR_ECALL  = 32'h0000_0073;
    localparam logic [31:0] INSTR_EBREAK = 32'h0010_0073;
    localparam logic [31:0] INSTR_MRET   = 32'h3020_0073;
    localparam logic [31:0] INSTR_WFI    = 32'h1050_0073;

    localparam int NUM_INSTR_CLASSES = 12;

    typedef enum logic [3:0] {
        CLS_ALU        = 4'd0,
        CLS_BRANCH     = 4'd1,
        CLS_JUMP       = 4'd2,
        CLS_LOAD       = 4'd3,
        CLS_STORE      = 4'd4,
        CLS_MULDIV     = 4'd5,
        CLS_PPU_ADDSUB = 4'd6,
        CLS_PPU_MUL    = 4'd7,
        CLS_PPU_DIV    = 4'd8,
        CLS_PPU_CVT    = 4'd9,
        CLS_SYSTEM     = 4'd10,
        CLS_OTHER      = 4'd11
    } instr_class_e;

    // Anything not positively recognised (illegal funct combos, MISC_MEM) is OTHER.
    function automatic instr_class_e classify_instr(input logic [31:0] instr);
        instr_class_e cls;
        logic [6:0]   opcode;
        logic [6:0]   funct7;
        logic [2:0]   funct3;
        opcode = instr[6:0];
        funct3 = instr[14:12];
        funct7 = instr[31:25];
        cls    = CLS_OTHER;
        case (opcode)
            OPCODE_LUI, OPCODE_AUIPC, OPCODE_OPIMM: cls = CLS_ALU;
            OPCODE_OP: begin
                if (funct7 == 7'b0000000) cls = CLS_ALU;
                else if (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101)) cls = CLS_ALU;
                else if (funct7 == 7'b0000001) cls = CLS_MULDIV;
            end
            OPCODE_BRANCH: if (funct3 != 3'b010 && funct3 != 3'b011) cls = CLS_BRANCH;
            OPCODE_JAL:    cls = CLS_JUMP;
            OPCODE_JALR:   if (funct3 == 3'b000) cls = CLS_JUMP;
            OPCODE_LOAD:   cls = CLS_LOAD;
            OPCODE_STORE:  cls = CLS_STORE;
            OPCODE_PPU: begin
                if (funct7 == PPU_F7_ARITH) begin
                    case (funct3)
                        3'b000, 3'b001: cls = CLS_PPU_ADDSUB;
                        3'b010:         cls = CLS_PPU_MUL;
                        3'b100:         cls = CLS_PPU_DIV;
                        default:        cls = CLS_OTHER;
                    endcase
                end else if ((funct7 == PPU_F7_F2P || funct7 == PPU_F7_P2F) && funct3 == 3'b000) begin
                    cls = CLS_PPU_CVT;
                end
            end
            OPCODE_SYSTEM: begin
                if (funct3 != 3'b000 && funct3 != 3'b100) cls = CLS_SYSTEM;
                else if (instr == INSTR_ECALL || instr == INSTR_EBREAK ||
                         instr == INSTR_MRET  || instr == INSTR_WFI) cls = CLS_SYSTEM;
            end
            default: cls = CLS_OTHER;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/zeroriscy_instr_classify.sv
// Combinational decoder from an instruction word to a one-hot class vector.
module zeroriscy_instr_classify
    import zeroriscy_instr_profiler_pkg::*;
(
    input  logic [31:0]                  instr,
    output logic [NUM_INSTR_CLASSES-1:0] class_onehot
);

    instr_class_e cls;

    always_comb begin
        cls               = classify_instr(instr);
        class_onehot      = '0;
        class_onehot[cls] = 1'b1;
    end

endmodule

// File: rtl/zeroriscy_instr_profiler.sv
// Retired-instruction profiler: two-stage decode pipeline, per-class live
// counters with sticky overflow, a snapshot shadow bank and a one-cycle read port.
module zeroriscy_instr_profiler
    import zeroriscy_instr_profiler_pkg::*;
#(
    parameter int                            CNT_W    = 32,
    parameter bit                            SATURATE = 1'b0,
    parameter logic [NUM_INSTR_CLASSES-1:0]  CLS_EN   = 12'hFFF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable_i,
    input  logic             instr_ret_i,
    input  logic [31:0]      instr_rdata_i,
    input  logic             clear_i,
    input  logic             snap_i,
    input  logic             rd_req_i,
    input  logic [3:0]       rd_idx_i,
    output logic             rd_valid_o,
    output logic [CNT_W-1:0] rd_data_o,
    output logic             rd_ovf_o,
    output logic             ovf_any_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [3:0]       IDX_LIM = 4'(NUM_INSTR_CLASSES);

    logic                          v1_q, v2_q;
    logic [31:0]                   instr_q;
    logic [NUM_INSTR_CLASSES-1:0]  hot_d, hot_q;
    logic [CNT_W-1:0]              cnt_q    [NUM_INSTR_CLASSES];
    logic [CNT_W-1:0]              shadow_q [NUM_INSTR_CLASSES];
    logic [NUM_INSTR_CLASSES-1:0]  ovf_q, shadow_ovf_q;

    zeroriscy_instr_classify u_classify (
        .instr        (instr_q),
        .class_onehot (hot_d)
    );

    // clear squashes anything in flight so it is never counted after the clear.
    always_ff @(posedge clk) begin
        if (rst || clear_i) begin
            v1_q    <= 1'b0;
            v2_q    <= 1'b0;
            instr_q <= '0;
            hot_q   <= '0;
        end else begin
            v1_q    <= instr_ret_i & enable_i;
            instr_q <= instr_rdata_i;
            v2_q    <= v1_q;
            hot_q   <= hot_d;
        end
    end

    // Snapshot copies pre-update values, so same-cycle increments/clear land after it.
    always_ff @(posedge clk) begin
        for (int k = 0; k < NUM_INSTR_CLASSES; k++) begin
            if (rst) begin
                cnt_q[k]        <= '0;
                ovf_q[k]        <= 1'b0;
                shadow_q[k]     <= '0;
                shadow_ovf_q[k] <= 1'b0;
            end else begin
                if (snap_i) begin
                    shadow_q[k]     <= cnt_q[k];
                    shadow_ovf_q[k] <= ovf_q[k];
                end
                if (clear_i) begin
                    cnt_q[k] <= '0;
                    ovf_q[k] <= 1'b0;
                end else if (v2_q && hot_q[k] && CLS_EN[k]) begin
                    if (cnt_q[k] == CNT_MAX) begin
                        ovf_q[k] <= 1'b1;
                        cnt_q[k] <= SATURATE ? CNT_MAX : '0;
                    end else begin
                        cnt_q[k] <= cnt_q[k] + CNT_ONE;
                    end
                end
            end
        end
    end

    // Read handshake: rd_req_i is always accepted; rd_valid_o pulses exactly one
    // cycle later with the shadow entry, and data/ovf hold between requests.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_valid_o <= 1'b0;
            rd_data_o  <= '0;
            rd_ovf_o   <= 1'b0;
        end else begin
            rd_valid_o <= rd_req_i;
            if (rd_req_i) begin
                if (rd_idx_i < IDX_LIM) begin
                    rd_data_o <= shadow_q[rd_idx_i];
                    rd_ovf_o  <= shadow_ovf_q[rd_idx_i];
                end else begin
                    rd_data_o <= '0;
                    rd_ovf_o  <= 1'b0;
                end
            end
        end
    end

    assign ovf_any_o = |ovf_q;

endmodule

// File: tb/tb_zeroriscy_instr_profiler.sv
// Bench for zeroriscy_instr_profiler: four parameter variants share one stimulus
// stream and are checked every cycle against a cycle-level behavioural model.
module tb_zeroriscy_instr_profiler;

    localparam int NC = 12;
    localparam logic [6:0] OPS [12] = '{7'h37, 7'h17, 7'h13, 7'h33, 7'h63, 7'h6f,
                                        7'h67, 7'h03, 7'h23, 7'h53, 7'h73, 7'h0f};
    localparam logic [6:0] F7S [6]  = '{7'h00, 7'h20, 7'h01, 7'h6a, 7'h68, 7'h69};
    localparam logic [31:0] SYSW [6] = '{32'h0000_0073, 32'h0010_0073, 32'h3020_0073,
                                         32'h1050_0073, 32'h0020_0073, 32'h0000_4073};

    // clock/reset and stimulus
    logic        clk = 1'b0;
    logic        rst;
    logic        enable_i, instr_ret_i, clear_i, snap_i, rd_req_i;
    logic [31:0] instr_rdata_i;
    logic [3:0]  rd_idx_i;
    always #5 clk = ~clk;

    logic [3:0]  rd_valid, rd_ovf, ovf_any;
    logic [31:0] d0, d3;
    logic [7:0]  d1, d2;

    zeroriscy_instr_profiler #(.CNT_W(32), .SATURATE(1'b0), .CLS_EN(12'hFFF)) dut (
        .clk(clk), .rst(rst), .enable_i(enable_i), .instr_ret_i(instr_ret_i),
        .instr_rdata_i(instr_rdata_i), .clear_i(clear_i), .snap_i(snap_i),
        .rd_req_i(rd_req_i), .rd_idx_i(rd_idx_i), .rd_valid_o(rd_valid[0]),
        .rd_data_o(d0), .rd_ovf_o(rd_ovf[0]), .ovf_any_o(ovf_any[0]));
    zeroriscy_instr_profiler #(.CNT_W(8), .SATURATE(1'b0), .CLS_EN(12'hFFF)) dut_wrap (
        .clk(clk), .rst(rst), .enable_i(enable_i), .instr_ret_i(instr_ret_i),
        .instr_rdata_i(instr_rdata_i), .clear_i(clear_i), .snap_i(snap_i),
        .rd_req_i(rd_req_i), .rd_idx_i(rd_idx_i), .rd_valid_o(rd_valid[1]),
        .rd_data_o(d1), .rd_ovf_o(rd_ovf[1]), .ovf_any_o(ovf_any[1]));
    zeroriscy_instr_profiler #(.CNT_W(8), .SATURATE(1'b1), .CLS_EN(12'hFFF)) dut_sat (
        .clk(clk), .rst(rst), .enable_i(enable_i), .instr_ret_i(instr_ret_i),
        .instr_rdata_i(instr_rdata_i), .clear_i(clear_i), .snap_i(snap_i),
        .rd_req_i(rd_req_i), .rd_idx_i(rd_idx_i), .rd_valid_o(rd_valid[2]),
        .rd_data_o(d2), .rd_ovf_o(rd_ovf[2]), .ovf_any_o(ovf_any[2]));
    zeroriscy_instr_profiler #(.CNT_W(32), .SATURATE(1'b0), .CLS_EN(12'hFFE)) dut_mask (
        .clk(clk), .rst(rst), .enable_i(enable_i), .instr_ret_i(instr_ret_i),
        .instr_rdata_i(instr_rdata_i), .clear_i(clear_i), .snap_i(snap_i),
        .rd_req_i(rd_req_i), .rd_idx_i(rd_idx_i), .rd_valid_o(rd_valid[3]),
        .rd_data_o(d3), .rd_ovf_o(rd_ovf[3]), .ovf_any_o(ovf_any[3]));

    // reference model state, one set per variant
    int          cfg_w   [4] = '{32, 8, 8, 32};
    bit          cfg_sat [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic [11:0] cfg_en  [4] = '{12'hFFF, 12'hFFF, 12'hFFF, 12'hFFE};
    longint      m_cnt   [4][NC];
    bit          m_ovf   [4][NC];
    longint      m_sh    [4][NC];
    bit          m_sh_ovf[4][NC];
    int          pipe_a, pipe_b;
    bit          e_valid;
    logic [63:0] e_data [4];
    bit          e_ovf  [4];

    int    tests = 0;
    int    fails = 0;
    string phase = "init";

    function automatic int ref_class(input logic [31:0] w);
        logic [6:0] op, f7;
        logic [2:0] f3;
        op = w[6:0]; f3 = w[14:12]; f7 = w[31:25];
        if (op == 7'h37 || op == 7'h17 || op == 7'h13) return 0;
        if (op == 7'h33) begin
            if (f7 == 7'h01) return 5;
            if (f7 == 7'h00) return 0;
            if (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)) return 0;
            return 11;
        end
        if (op == 7'h63) return (f3 == 3'd2 || f3 == 3'd3) ? 11 : 1;
        if (op == 7'h6f) return 2;
        if (op == 7'h67) return (f3 == 3'd0) ? 2 : 11;
        if (op == 7'h03) return 3;
        if (op == 7'h23) return 4;
        if (op == 7'h53) begin
            if (f7 == 7'h6a && f3 <= 3'd1) return 6;
            if (f7 == 7'h6a && f3 == 3'd2) return 7;
            if (f7 == 7'h6a && f3 == 3'd4) return 8;
            if ((f7 == 7'h68 || f7 == 7'h69) && f3 == 3'd0) return 9;
            return 11;
        end
        if (op == 7'h73) begin
            if (f3 != 3'd0 && f3 != 3'd4) return 10;
            if (w == 32'h0000_0073 || w == 32'h0010_0073 || w == 32'h3020_0073 || w == 32'h1050_0073) return 10;
        end
        return 11;
    endfunction

    function automatic logic [31:0] rand_word();
        logic [31:0] w;
        w = $urandom;
        case ($urandom_range(0, 9))
            0: w = SYSW[$urandom_range(0, 5)];
            8, 9: ;
            default: begin
                w[6:0] = OPS[$urandom_range(0, 11)];
                if ($urandom_range(0, 2) != 0) w[31:25] = F7S[$urandom_range(0, 5)];
            end
        endcase
        return w;
    endfunction

    task automatic model_edge();
        if (rst) begin
            for (int c = 0; c < 4; c++) begin
                for (int k = 0; k < NC; k++) begin
                    m_cnt[c][k] = 0; m_ovf[c][k] = 0; m_sh[c][k] = 0; m_sh_ovf[c][k] = 0;
                end
                e_data[c] = '0; e_ovf[c] = 0;
            end
            pipe_a = -1; pipe_b = -1; e_valid = 0;
            return;
        end
        e_valid = rd_req_i;
        if (rd_req_i) begin
            for (int c = 0; c < 4; c++) begin
                e_data[c] = (rd_idx_i < 12) ? 64'(m_sh[c][rd_idx_i]) : 64'd0;
                e_ovf[c]  = (rd_idx_i < 12) ? m_sh_ovf[c][rd_idx_i] : 1'b0;
            end
        end
        if (snap_i) begin
            for (int c = 0; c < 4; c++)
                for (int k = 0; k < NC; k++) begin
                    m_sh[c][k] = m_cnt[c][k]; m_sh_ovf[c][k] = m_ovf[c][k];
                end
        end
        if (clear_i) begin
            for (int c = 0; c < 4; c++)
                for (int k = 0; k < NC; k++) begin
                    m_cnt[c][k] = 0; m_ovf[c][k] = 0;
                end
            pipe_a = -1; pipe_b = -1;
        end else begin
            if (pipe_b >= 0) begin
                for (int c = 0; c < 4; c++) begin
                    longint mx;
                    mx = (longint'(1) << cfg_w[c]) - 1;
                    if (cfg_en[c][pipe_b]) begin
                        if (m_cnt[c][pipe_b] == mx) begin
                            m_ovf[c][pipe_b] = 1;
                            m_cnt[c][pipe_b] = cfg_sat[c] ? mx : 0;
                        end else begin
                            m_cnt[c][pipe_b] = m_cnt[c][pipe_b] + 1;
                        end
                    end
                end
            end
            pipe_b = pipe_a;
            pipe_a = (instr_ret_i && enable_i) ? ref_class(instr_rdata_i) : -1;
        end
    endtask

    // scoreboard check of every output of every variant against the model
    task automatic check_outputs();
        logic [63:0] dd [4];
        bit          any;
        dd[0] = {32'h0, d0}; dd[1] = {56'h0, d1}; dd[2] = {56'h0, d2}; dd[3] = {32'h0, d3};
        for (int c = 0; c < 4; c++) begin
            any = 0;
            for (int k = 0; k < NC; k++) any = any | m_ovf[c][k];
            tests++;
            assert (rd_valid[c] === e_valid) else begin
                fails++; $error("FAIL %s rd_valid cfg%0d: got %b expected %b", phase, c, rd_valid[c], e_valid);
            end
            tests++;
            assert (dd[c] === e_data[c]) else begin
                fails++; $error("FAIL %s rd_data cfg%0d: got %0d expected %0d", phase, c, dd[c], e_data[c]);
            end
            tests++;
            assert (rd_ovf[c] === e_ovf[c]) else begin
                fails++; $error("FAIL %s rd_ovf cfg%0d: got %b expected %b", phase, c, rd_ovf[c], e_ovf[c]);
            end
            tests++;
            assert (ovf_any[c] === any) else begin
                fails++; $error("FAIL %s ovf_any cfg%0d: got %b expected %b", phase, c, ovf_any[c], any);
            end
        end
    endtask

    task automatic expect_const(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++; $error("FAIL %s %s: got %0d expected %0d", phase, tag, got, exp);
        end
    endtask

    // driver: one clock cycle of stimulus, then model update and output check
    task automatic step(input bit ret, input logic [31:0] w, input bit req,
                        input logic [3:0] idx, input bit snap, input bit clr);
        instr_ret_i = ret; instr_rdata_i = w; rd_req_i = req;
        rd_idx_i = idx; snap_i = snap; clear_i = clr;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 32'h0, 1'b0, 4'd0, 1'b0, 1'b0);
    endtask

    task automatic retire(input logic [31:0] w);
        step(1'b1, w, 1'b0, 4'd0, 1'b0, 1'b0);
    endtask

    task automatic read(input logic [3:0] idx);
        step(1'b0, 32'h0, 1'b1, idx, 1'b0, 1'b0);
    endtask

    localparam logic [31:0] W_ADD  = 32'h0031_00b3;
    localparam logic [31:0] W_ADDI = 32'h0051_0093;
    localparam logic [31:0] W_LUI  = 32'h0000_10b7;
    localparam logic [31:0] W_PADD = {7'h6a, 5'd3, 5'd2, 3'b000, 5'd1, 7'h53};
    localparam logic [31:0] W_PMUL = {7'h6a, 5'd3, 5'd2, 3'b010, 5'd1, 7'h53};
    localparam logic [31:0] W_PDIV = {7'h6a, 5'd3, 5'd2, 3'b100, 5'd1, 7'h53};
    localparam logic [31:0] W_F2P  = {7'h68, 5'd0, 5'd2, 3'b000, 5'd1, 7'h53};
    localparam logic [31:0] W_BALL = {7'h00, 5'd3, 5'd2, 3'b010, 5'd8, 7'h63};

    initial begin
        rst = 1'b1; enable_i = 1'b1;
        instr_ret_i = 0; instr_rdata_i = '0; clear_i = 0; snap_i = 0; rd_req_i = 0; rd_idx_i = '0;

        phase = "reset";
        idle(2);
        rst = 1'b0;
        step(1'b0, 32'h0, 1'b0, 4'd0, 1'b1, 1'b0);
        for (int i = 0; i < 12; i++) read(4'(i));

        phase = "mix";
        retire(W_ADD); retire(W_PMUL); retire(W_F2P); retire(W_BALL);
        idle(3);
        step(1'b0, 32'h0, 1'b0, 4'd0, 1'b1, 1'b0);
        for (int i = 0; i < 12; i++) begin
            read(4'(i));
            expect_const($sformatf("class%0d", i), {32'h0, d0}, (i == 0 || i == 7 || i == 9 || i == 11) ? 64'd1 : 64'd0);
        end

        phase = "wrap";
        step(1'b0, 32'h0, 1'b0, 4'd0, 1'b0, 1'b1);
        idle(2);
        for (int i = 0; i < 257; i++) retire(W_LUI);
        idle(3);
        step(1'b0, 32'h0, 1'b0, 4'd0, 1'b1, 1'b0);
        read(4'd0);
        expect_const("wrap_data", {56'h0, d1}, 64'd1);
        expect_const("wrap_ovf", {63'h0, rd_ovf[1]}, 64'd1);
        expect_const("wrap_any", {63'h0, ovf_any[1]}, 64'd1);
        expect_const("sat_data", {56'h0, d2}, 64'd255);
        expect_const("sat_ovf", {63'h0, rd_ovf[2]}, 64'd1);
        expect_const("wide_data", {32'h0, d0}, 64'd257);

        phase = "snap_clear";
        step(1'b0, 32'h0, 1'b0, 4'd0, 1'b0, 1'b1);
        idle(2);
        for (int i = 0; i < 5; i++)
            step(1'b1, W_ADDI, i == 3, 4'd0, i == 2, i == 2);
        expect_const("shadow_pre_clear", {32'h0, d0}, 64'd0);
        idle(3);
        step(1'b0, 32'h0, 1'b0, 4'd0, 1'b1, 1'b0);
        read(4'd0);
        expect_const("after_squash", {32'h0, d0}, 64'd2);

        phase = "cls_en";
        step(1'b0, 32'h0, 1'b0, 4'd0, 1'b0, 1'b1);
        idle(2);
        for (int i = 0; i < 10; i++) retire(W_ADD);
        idle(3);
        step(1'b0, 32'h0, 1'b0, 4'd0, 1'b1, 1'b0);
        read(4'd0);
        expect_const("masked", {32'h0, d3}, 64'd0);
        expect_const("unmasked", {32'h0, d0}, 64'd10);
        read(4'd13);
        expect_const("idx13_valid", {63'h0, rd_valid[0]}, 64'd1);
        expect_const("idx13_data", {32'h0, d0}, 64'd0);

        phase = "read_snap";
        retire(W_PADD); retire(W_PADD); retire(W_PMUL); retire(W_PMUL); retire(W_PMUL); retire(W_PDIV);
        idle(3);
        step(1'b0, 32'h0, 1'b1, 4'd6, 1'b1, 1'b0);
        expect_const("old_shadow6", {32'h0, d0}, 64'd0);
        read(4'd7);
        expect_const("new_shadow7", {32'h0, d0}, 64'd3);
        read(4'd8);
        expect_const("new_shadow8", {32'h0, d0}, 64'd1);
        idle(1);

        phase = "random";
        for (int i = 0; i < 600; i++) begin
            enable_i = ($urandom_range(0, 9) != 0);
            rst = (i == 300);
            step($urandom_range(0, 9) < 7, rand_word(), $urandom_range(0, 1) == 1,
                 4'($urandom_range(0, 15)), $urandom_range(0, 19) == 0, $urandom_range(0, 99) == 0);
            if (i == 300) begin
                expect_const("rst_valid", {60'h0, rd_valid}, 64'd0);
                expect_const("rst_data", {32'h0, d0}, 64'd0);
                expect_const("rst_any", {60'h0, ovf_any}, 64'd0);
            end
        end
        rst = 1'b0; enable_i = 1'b1;
        step(1'b0, 32'h0, 1'b0, 4'd0, 1'b1, 1'b0);
        for (int i = 0; i < 16; i++) read(4'(i));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/zeroriscy_instr_profiler.md
Name: zeroriscy_instr_profiler

Overview:
- Parametrised retired-instruction profiler for the zeroriscy/PPU core.
- Decodes each retired 32-bit instruction into one of 12 classes, including separate posit (PPU) operation classes, and keeps a counter per class.
- Software or debug logic captures all counters atomically into a shadow bank and reads them back one by one through a request/valid port.
- Sits beside the tracer, fed from the writeback/retire stage.

Parameters:
- CNT_W, 32: counter width in bits (legal range 8..64).
- SATURATE, 0: 0 = counters wrap to 0 on overflow; 1 = counters hold at 2^CNT_W-1.
- CLS_EN, 12'hFFF: per-class count enable; bit k = 0 keeps class k permanently at 0.

Ports:
- clk  in  1  core clock.
- rst  in  1  synchronous, active-high reset.
- enable_i  in  1  global count enable, sampled at the input stage.
- instr_ret_i  in  1  one instruction retires this cycle.
- instr_rdata_i  in  32  retired instruction word (decompressed).
- clear_i  in  1  zero all live counters and overflow flags.
- snap_i  in  1  copy live counters and flags into the shadow bank.
- rd_req_i  in  1  read request.
- rd_idx_i  in  4  class index to read.
- rd_valid_o  out  1  read data valid.
- rd_data_o  out  CNT_W  shadow counter value.
- rd_ovf_o  out  1  shadow sticky overflow flag for the class that was read.
- ovf_any_o  out  1  OR of all live overflow flags.

Behaviour:
- Reset. All counters, flags and shadow entries are 0; both pipeline registers are cleared; rd_valid_o, rd_data_o, rd_ovf_o and ovf_any_o are all 0.
- Stage 1 (cycle t). Register instr_rdata_i together with v1 = instr_ret_i & enable_i.
- Stage 2 (cycle t+1). Decode the registered word into a class one-hot and register it with v2.
- Counter update (cycle t+2). Increment the selected counter when v2 is set and CLS_EN[k] = 1. Increment-to-visibility latency is 2 cycles.
- Class encoding. Opcode values come from zeroriscy_defines.
  - 0 ALU: OP with funct7 = 0000000 or 0100000 and a legal funct3/funct7 pair; OPIMM; LUI; AUIPC.
  - 1 BRANCH: BRANCH with funct3 in {000, 001, 100, 101, 110, 111}. funct3 = 010 (BALL) falls into class 11.
  - 2 JUMP: JAL; JALR with funct3 = 000.
  - 3 LOAD.
  - 4 STORE.
  - 5 MULDIV: OP with funct7 = 0000001, any funct3.
  - 6 PPU_ADDSUB: PPU_OP with funct7 = 1101010 and funct3 in {000, 001}.
  - 7 PPU_MUL: funct7 = 1101010, funct3 = 010.
  - 8 PPU_DIV: funct7 = 1101010, funct3 = 100.
  - 9 PPU_CVT: funct7 in {1101000, 1101001} with funct3 = 000.
  - 10 SYSTEM: CSR ops with funct3 in {001, 010, 011, 101, 110, 111}; exact ECALL, EBREAK, MRET and WFI encodings.
  - 11 OTHER: everything else, including unlisted PPU funct3/funct7 combinations and MISC_MEM.
- Overflow.
  - When an increment at 2^CNT_W-1 occurs, set the class's sticky ovf flag.
  - The counter becomes 0 if SATURATE = 0, otherwise it stays at max.
  - Flags clear only on clear_i or rst.
- clear_i.
  - Next cycle: all live counters = 0, flags = 0, and v1/v2 are squashed, so instructions still in the pipeline are not counted.
  - An increment in the same cycle as clear_i is lost; clear wins.
  - The shadow bank is untouched.
- snap_i. Copies the live counters and flags into the shadow bank as registered at cycle t, before any same-cycle increment or clear.
- snap_i and clear_i in the same cycle: the shadow receives the pre-clear values. This is the intended read-and-reset idiom.
- Read port.
  - rd_req_i at cycle t gives rd_valid_o = 1 at t+1, with rd_data_o/rd_ovf_o taken from the shadow entry rd_idx_i.
  - Back-to-back requests are allowed at one per cycle.
  - rd_idx_i >= 12 returns data 0 and ovf 0 with rd_valid_o still asserted.
  - A read in the same cycle as snap_i returns the old shadow value.
  - With no request, rd_valid_o = 0 and rd_data_o/rd_ovf_o hold their last values.
- enable_i low stops new counts. Instructions already in the pipeline still complete their count.
- rst asserted mid-operation aborts everything in flight and returns the block to the reset state on the next edge.

Decomposition:
- Add to zeroriscy_tracer_defines:
  - the class enum instr_class_e (12 entries, 4 bits);
  - constant NUM_INSTR_CLASSES = 12;
  - a pure function for class decode, shared with the tracer.
- The PPU funct7 constants PPU_F7_ARITH, PPU_F7_F2P and PPU_F7_P2F go in zeroriscy_defines.
- One sub-module, zeroriscy_instr_classify: a purely combinational word-to-one-hot decoder, instantiated in stage 2 and reusable by the tracer.

Test Plan:
- Reset, snap, then read indices 0..11 -> every read gives rd_valid_o = 1, data 0, ovf 0, and ovf_any_o = 0.
- Retire ADD, PPU_MUL (funct7 1101010, funct3 010), PPU_F2P and BALL on consecutive cycles, wait 3 cycles, snap, read -> class 0 = 1, class 7 = 1, class 9 = 1, class 11 = 1, all others 0.
- Wrap case: CNT_W = 8, SATURATE = 0, 257 LUI retirements -> class 0 = 1 with rd_ovf_o = 1 and ovf_any_o = 1. Same stimulus with SATURATE = 1 -> class 0 = 255 with ovf = 1.
- Retire 5 ADDI, then on the cycle of the third retire assert snap_i and clear_i together -> shadow class 0 = 0 (2-cycle latency). After 3 more cycles, snap again -> class 0 = 2, since in-flight instructions are squashed by the clear.
- CLS_EN = 12'hFFE with 10 ADDs retired -> class 0 stays 0. Then read rd_idx_i = 13 -> rd_valid_o = 1, data 0.
- Assert rd_req_i on every cycle for indices 6, 7, 8 while snap_i pulses in the first cycle -> the first read returns the old shadow value and the later reads return the new one. Finally, assert rst mid-stream -> all outputs are 0 on the next cycle.
